spi_ram_burst: RTL
==================

Name: spi_ram_burst

Overview:
SPI slave with an embedded single-port RAM, parametrised in data width and address width. Adds auto-incrementing burst read and burst write transfers to the existing single-word access model. Sits at the chip SPI boundary, where it replaces the fixed 8-bit slave-plus-RAM pair. MOSI is sampled on clk while SS_n is low.

Parameters:
DATA_WIDTH, 8, bits per memory word and per SPI data word
ADDR_SIZE, 8, address bits carried in the frame header
MEM_DEPTH, 256, number of words; must equal 2**ADDR_SIZE (elaboration error otherwise)
BURST_EN, 1, 1 enables burst opcodes; 0 makes burst opcodes behave as single accesses

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous reset, active low
SS_n  in  1  slave select, active low; high ends/aborts frame
MOSI  in  1  serial data in, MSB first
MISO  out  1  serial data out, MSB first, registered
busy  out  1  registered; 1 while FSM not in IDLE
burst_wrap  out  1  one-cycle pulse when burst address wraps MEM_DEPTH-1 -> 0

Behaviour:
- Reset: asynchronous, active low (rst_n). State=IDLE, MISO=0, busy=0, burst_wrap=0; address and shift registers cleared. RAM contents not cleared.
- Edge numbering: edge 0 = first rising edge with SS_n sampled low. H = ADDR_SIZE+2.
- Header: edges 0..H-1 sample opcode[1:0] then addr[ADDR_SIZE-1:0], MSB first.
- Opcodes: 00 single write, 01 burst write, 10 single read, 11 burst read.
- States: IDLE, HEADER, WR_DATA, RD_TURN, RD_DATA, DONE.
- IDLE -> HEADER on SS_n low; bit 0 is sampled on the same edge.
- HEADER -> WR_DATA or RD_TURN after edge H-1.
- Write: word n occupies edges H+n*DW .. H+(n+1)*DW-1 (DW=DATA_WIDTH).
  - mem[addr+n] is written on the edge that samples the word's last bit.
  - Single write -> DONE after word 0.
  - Burst write stays in WR_DATA; address increments after each completed word.
- Read:
  - Edge H (RD_TURN): registered RAM read of addr; MOSI ignored.
  - Edge H+1 loads the shift register; MISO = data[DW-1] after edge H+1 and data[DW-k] after edge H+k, k=1..DW.
  - Burst read prefetches addr+1 on edge H+1 and loads the next word on edge H+DW+1, giving contiguous words with no gap cycles.
  - Single read -> DONE after DW bits.
- DONE: MISO=0, MOSI ignored, no RAM access until SS_n high.
- Address arithmetic: ADDR_SIZE-bit modulo increment. burst_wrap pulses for one cycle on the edge the address goes MEM_DEPTH-1 -> 0.
- MISO is 0 in IDLE, HEADER, RD_TURN and DONE.
- SS_n high in any state:
  - FSM -> IDLE on that edge; MISO=0 and busy=0 after it.
  - A partially received write word is discarded; completed words remain written.
  - A read in progress is truncated; no RAM writes occur.
- SS_n low again on the edge after returning to IDLE starts a new frame.
- rst_n low mid-frame: immediate return to reset values; RAM retains contents; a new frame needs SS_n high then low.
- BURST_EN=0: opcodes 01/11 act as 00/10 and go to DONE after one word; burst_wrap stays 0.
- A read and a write never target the RAM in the same cycle (single port).

Test Plan:
- Single write then read (DW=8, ADDR_SIZE=8): frame 00 + 0x3C + 0xA5, SS_n high; frame 10 + 0x3C -> MISO 1,0,1,0,0,1,0,1 after edges 11..18, then 0; busy 1 only during frames.
- Burst wrap: write 01 + 0xFE + 0x11,0x22,0x33 -> mem[FE]=11, mem[FF]=22, mem[00]=33; burst_wrap one pulse after second word. Burst read 11 + 0xFE over 24 data edges -> 0x11,0x22,0x33 contiguous on MISO.
- Abort: 01 + 0x10 + 0x5A + 4 bits 1111, SS_n high -> mem[10]=5A, mem[11] unchanged; busy=0 and MISO=0 after next edge.
- Reset mid-read: assert rst_n low at edge H+4 of a read -> MISO=0, busy=0 immediately; re-read of the same address returns the pre-reset value.
- Single read overrun: 10 + 0x3C, 16 data edges -> 0xA5 then 8 zeros; RAM unchanged.
- BURST_EN=0: 01 + 0x20 + 0x77,0x88 -> mem[20]=77, mem[21] unchanged, burst_wrap never asserted.

Source files
------------

// File: rtl/spi_ram_burst.sv
// spi_ram_burst
//   SPI slave fronting a single-port RAM. A frame carries a 2-bit opcode and an
//   ADDR_SIZE-bit address (MSB first), followed by write data on MOSI or read
//   data on MISO. Burst opcodes auto-increment the address modulo MEM_DEPTH.
//
//   Opcodes: 00 single write, 01 burst write, 10 single read, 11 burst read.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active low (RAM contents are kept)
//   SS_n       slave select, active low; high ends or aborts the frame
//   MOSI       serial data in, MSB first
//   MISO       serial data out, MSB first, registered
//   busy       registered, 1 while the FSM is out of IDLE
//   burst_wrap one-cycle pulse when a burst address steps MEM_DEPTH-1 -> 0
module spi_ram_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit BURST_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic burst_wrap
);

    localparam int DW  = DATA_WIDTH;
    localparam int H   = ADDR_SIZE + 2;
    localparam int HCW = $clog2(H);
    localparam int BCW = $clog2(DW + 1);

    localparam logic [HCW-1:0]       H_LAST = HCW'(H - 1);
    localparam logic [HCW-1:0]       H_ONE  = HCW'(1);
    localparam logic [BCW-1:0]       B_LAST = BCW'(DW - 1);
    localparam logic [BCW-1:0]       B_FULL = BCW'(DW);
    localparam logic [BCW-1:0]       B_ONE  = BCW'(1);
    localparam logic [ADDR_SIZE-1:0] A_ONE  = ADDR_SIZE'(1);

    if (MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
        $error("spi_ram_burst: MEM_DEPTH must equal 2**ADDR_SIZE");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("spi_ram_burst: DATA_WIDTH must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, HEADER, WR_DATA, RD_TURN, RD_DATA, DONE} state_t;

    state_t                 state;
    logic [H-2:0]           hsh;     // header bits received so far
    logic [HCW-1:0]         hcnt;
    logic [ADDR_SIZE-1:0]   addr;
    logic                   burst;
    logic [DW-2:0]          wsh;     // write word bits received so far
    logic [BCW-1:0]         bcnt;    // bit count within current data word
    logic [DW-1:0]          rsh;     // outgoing read word
    logic [DW-1:0]          rdata;   // registered RAM read port
    logic                   armed;   // SS_n seen high since reset/last frame start
    logic [DW-1:0]          mem [MEM_DEPTH];

    logic [H-1:0]           h_next;
    logic [DW-1:0]          w_next;
    logic [ADDR_SIZE-1:0]   addr_inc;
    logic                   rd_load;
    logic                   ram_we;
    logic                   ram_re;
    logic [ADDR_SIZE-1:0]   ram_addr;

    assign h_next   = {hsh, MOSI};
    assign w_next   = {wsh, MOSI};
    assign addr_inc = addr + A_ONE;

    // Word load edge in RD_DATA: the first one after the turnaround, and for
    // bursts every DW edges after that so words stream back to back.
    assign rd_load  = (state == RD_DATA) && ((bcnt == '0) || (burst && (bcnt == B_FULL)));
    assign ram_we   = !SS_n && (state == WR_DATA) && (bcnt == B_LAST);
    // Turnaround fetches the start address; burst loads prefetch the next one.
    assign ram_re   = !SS_n && ((state == RD_TURN) || (rd_load && burst));
    assign ram_addr = (state == RD_DATA) ? addr_inc : addr;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= w_next;
        if (ram_re) rdata <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            MISO       <= 1'b0;
            busy       <= 1'b0;
            burst_wrap <= 1'b0;
            hsh        <= '0;
            hcnt       <= '0;
            addr       <= '0;
            burst      <= 1'b0;
            wsh        <= '0;
            bcnt       <= '0;
            rsh        <= '0;
            armed      <= 1'b0;
        end else begin
            burst_wrap <= 1'b0;
            if (SS_n) begin
                state <= IDLE;
                MISO  <= 1'b0;
                busy  <= 1'b0;
                armed <= 1'b1;
                hcnt  <= '0;
                bcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // After reset a frame only starts once SS_n has been high.
                        if (armed) begin
                            state <= HEADER;
                            busy  <= 1'b1;
                            armed <= 1'b0;
                            hsh   <= h_next[H-2:0];
                            hcnt  <= H_ONE;
                        end
                    end
                    HEADER: begin
                        hsh  <= h_next[H-2:0];
                        hcnt <= hcnt + H_ONE;
                        if (hcnt == H_LAST) begin
                            hcnt  <= '0;
                            addr  <= h_next[ADDR_SIZE-1:0];
                            burst <= h_next[H-2] & BURST_EN;
                            state <= h_next[H-1] ? RD_TURN : WR_DATA;
                            bcnt  <= '0;
                        end
                    end
                    WR_DATA: begin
                        wsh <= w_next[DW-2:0];
                        if (bcnt == B_LAST) begin
                            bcnt <= '0;
                            if (burst) begin
                                addr <= addr_inc;
                                if (&addr) burst_wrap <= 1'b1;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            bcnt <= bcnt + B_ONE;
                        end
                    end
                    RD_TURN: begin
                        state <= RD_DATA;
                        bcnt  <= '0;
                    end
                    RD_DATA: begin
                        if (rd_load) begin
                            MISO <= rdata[DW-1];
                            rsh  <= {rdata[DW-2:0], 1'b0};
                            bcnt <= B_ONE;
                            if (burst) begin
                                addr <= addr_inc;
                                if (&addr) burst_wrap <= 1'b1;
                            end
                        end else if (bcnt == B_FULL) begin
                            state <= DONE;
                            MISO  <= 1'b0;
                        end else begin
                            MISO <= rsh[DW-1];
                            rsh  <= {rsh[DW-2:0], 1'b0};
                            bcnt <= bcnt + B_ONE;
                        end
                    end
                    DONE: begin
                        MISO <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        MISO  <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
